stop_watch_lap: RTL and testbench

//  Parametrised BCD stopwatch: successor to the fixed 3-digit stopwatch counter.

---
 rtl/stop_watch_lap.sv | 143 ++++++++++++++
 tb/tb_stop_watch_lap.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/stop_watch_lap.sv
// N-digit BCD stopwatch with programmable prescaler, up/down counting,
// wrap or saturate at the limits, sticky overflow and a lap display freeze.
module stop_watch_lap #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 10_000_000,
    parameter bit WRAP     = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic                clr,
    input  logic                up,
    input  logic                lap,
    output logic [4*DIGITS-1:0] d_out,
    output logic                lap_active,
    output logic                ovf
);

    localparam int CW = 4 * DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PSC_LAST = PW'(TICK_DIV - 1);

    function automatic logic [CW-1:0] all_nines();
        logic [CW-1:0] r;
        r = {CW{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    localparam logic [CW-1:0] NINES = all_nines();

    // Ripple a single +1/-1 through the digits; digits stay in 0..9.
    function automatic logic [CW-1:0] bcd_step(input logic [CW-1:0] v, input logic dir_up);
        logic [CW-1:0] r;
        logic          c;
        logic [3:0]    dg;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            dg = v[4*i +: 4];
            if (c) begin
                if (dir_up) begin
                    if (dg == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = dg + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (dg == 4'd0) begin
                        r[4*i +: 4] = 4'd9;
                    end else begin
                        r[4*i +: 4] = dg - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    logic [PW-1:0] psc_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] snap_r;
    logic          lap_q_r;
    logic          lap_active_r;
    logic          ovf_r;

    logic          tick_s;
    logic          lap_rise_s;
    logic [CW-1:0] cnt_nxt_s;
    logic          limit_s;

    assign tick_s     = go & (psc_r == PSC_LAST);
    assign lap_rise_s = lap & ~lap_q_r;

    // Next count value on a tick, including limit handling
    always_comb begin
        cnt_nxt_s = cnt_r;
        limit_s   = 1'b0;
        if (up) begin
            if (cnt_r == NINES) begin
                limit_s   = 1'b1;
                cnt_nxt_s = WRAP ? {CW{1'b0}} : NINES;
            end else begin
                cnt_nxt_s = bcd_step(cnt_r, 1'b1);
            end
        end else begin
            if (cnt_r == {CW{1'b0}}) begin
                limit_s   = 1'b1;
                cnt_nxt_s = WRAP ? NINES : {CW{1'b0}};
            end else begin
                cnt_nxt_s = bcd_step(cnt_r, 1'b0);
            end
        end
    end

    // Prescaler, count, overflow and lap state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psc_r        <= {PW{1'b0}};
            cnt_r        <= {CW{1'b0}};
            snap_r       <= {CW{1'b0}};
            lap_q_r      <= 1'b0;
            lap_active_r <= 1'b0;
            ovf_r        <= 1'b0;
        end else begin
            lap_q_r <= lap;
            if (clr) begin
                psc_r        <= {PW{1'b0}};
                cnt_r        <= {CW{1'b0}};
                ovf_r        <= 1'b0;
                lap_active_r <= 1'b0;
            end else begin
                if (go) begin
                    psc_r <= tick_s ? {PW{1'b0}} : psc_r + PW'(1);
                end
                if (tick_s) begin
                    cnt_r <= cnt_nxt_s;
                    if (limit_s) begin
                        ovf_r <= 1'b1;
                    end
                end
                // Snapshot takes the pre-update count when a tick coincides
                if (lap_rise_s) begin
                    if (!lap_active_r) begin
                        snap_r       <= cnt_r;
                        lap_active_r <= 1'b1;
                    end else begin
                        lap_active_r <= 1'b0;
                    end
                end
            end
        end
    end

    assign d_out      = lap_active_r ? snap_r : cnt_r;
    assign lap_active = lap_active_r;
    assign ovf        = ovf_r;

endmodule

// File: tb/tb_stop_watch_lap.sv
// Scoreboard bench: an integer reference model pushes expected outputs for a
// wrapping and a saturating instance each cycle; a monitor pops and compares.
module tb_stop_watch_lap;

    localparam int TD = 4;

    logic clk = 1'b0;
    logic reset, go, clr, up, lap;
    logic [11:0] d_w, d_s;
    logic la_w, la_s, ov_w, ov_s;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [11:0] d;
        logic        la;
        logic        ov;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    stop_watch_lap #(.DIGITS(3), .TICK_DIV(TD), .WRAP(1'b1)) dut (
        .clk(clk), .reset(reset), .go(go), .clr(clr), .up(up), .lap(lap),
        .d_out(d_w), .lap_active(la_w), .ovf(ov_w)
    );

    stop_watch_lap #(.DIGITS(3), .TICK_DIV(TD), .WRAP(1'b0)) dut_sat (
        .clk(clk), .reset(reset), .go(go), .clr(clr), .up(up), .lap(lap),
        .d_out(d_s), .lap_active(la_s), .ovf(ov_s)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Reference model: index 0 wraps, index 1 saturates.
    int m_cnt[2], m_snap[2];
    bit m_ovf[2], m_la[2];
    int m_psc = 0;
    bit m_lapq = 1'b0;

    initial begin
        bit rise, tick;
        int old;
        exp_t e;
        for (int m = 0; m < 2; m++) begin
            m_cnt[m] = 0; m_snap[m] = 0; m_ovf[m] = 1'b0; m_la[m] = 1'b0;
        end
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int m = 0; m < 2; m++) begin
                    m_cnt[m] = 0; m_snap[m] = 0; m_ovf[m] = 1'b0; m_la[m] = 1'b0;
                end
                m_psc  = 0;
                m_lapq = 1'b0;
            end else begin
                rise = lap && !m_lapq;
                tick = go && (m_psc == TD - 1);
                for (int m = 0; m < 2; m++) begin
                    old = m_cnt[m];
                    if (clr) begin
                        m_cnt[m] = 0; m_ovf[m] = 1'b0; m_la[m] = 1'b0;
                    end else begin
                        if (tick) begin
                            if (up) begin
                                if (old == 999) begin
                                    m_ovf[m] = 1'b1;
                                    m_cnt[m] = (m == 0) ? 0 : 999;
                                end else m_cnt[m] = old + 1;
                            end else begin
                                if (old == 0) begin
                                    m_ovf[m] = 1'b1;
                                    m_cnt[m] = (m == 0) ? 999 : 0;
                                end else m_cnt[m] = old - 1;
                            end
                        end
                        if (rise) begin
                            if (!m_la[m]) begin
                                m_snap[m] = old;
                                m_la[m]   = 1'b1;
                            end else m_la[m] = 1'b0;
                        end
                    end
                end
                if (clr) m_psc = 0;
                else if (go) m_psc = (m_psc == TD - 1) ? 0 : m_psc + 1;
                m_lapq = lap;
            end
            for (int m = 0; m < 2; m++) begin
                e.d  = to_bcd(m_la[m] ? m_snap[m] : m_cnt[m]);
                e.la = m_la[m];
                e.ov = m_ovf[m];
                sbq.push_back(e);
            end
        end
    end

    // Monitor: compare both instances once per cycle on the falling edge
    initial begin
        exp_t ew, es;
        forever begin
            @(negedge clk);
            if (sbq.size() >= 2) begin
                ew = sbq.pop_front();
                es = sbq.pop_front();
                chk("sb_wrap_d", 32'(d_w), 32'(ew.d));
                chk("sb_wrap_lap", 32'(la_w), 32'(ew.la));
                chk("sb_wrap_ovf", 32'(ov_w), 32'(ew.ov));
                chk("sb_sat_d", 32'(d_s), 32'(es.d));
                chk("sb_sat_lap", 32'(la_s), 32'(es.la));
                chk("sb_sat_ovf", 32'(ov_s), 32'(es.ov));
            end
        end
    end

    task automatic run_ticks(input int n);
        go = 1'b1;
        repeat (TD * n) @(negedge clk);
        go = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1;
        @(negedge clk);
        lap = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; clr = 1'b0; up = 1'b1; lap = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_d", 32'(d_w), 32'h000);
        chk("reset_ovf", 32'(ov_w), 32'h0);
        chk("reset_lap", 32'(la_w), 32'h0);

        run_ticks(10);
        chk("ten_ticks_d", 32'(d_w), 32'h010);
        chk("ten_ticks_ovf", 32'(ov_w), 32'h0);

        run_ticks(989);
        chk("at_999", 32'(d_w), 32'h999);
        run_ticks(1);
        chk("wrap_up_d", 32'(d_w), 32'h000);
        chk("wrap_up_ovf", 32'(ov_w), 32'h1);
        chk("sat_up_d", 32'(d_s), 32'h999);
        chk("sat_up_ovf", 32'(ov_s), 32'h1);

        run_ticks(42);
        chk("pre_clr_d", 32'(d_w), 32'h042);
        go = 1'b1;
        repeat (TD - 1) @(negedge clk);
        clr = 1'b1; lap = 1'b1;
        @(negedge clk);
        clr = 1'b0; go = 1'b0;
        chk("clr_tick_lap_d", 32'(d_w), 32'h000);
        chk("clr_tick_lap_ovf", 32'(ov_w), 32'h0);
        chk("clr_tick_lap_la", 32'(la_w), 32'h0);
        lap = 1'b0;
        @(negedge clk);

        run_ticks(100);
        up = 1'b0;
        run_ticks(1);
        chk("down_100_d", 32'(d_w), 32'h099);
        pulse_clr();
        run_ticks(1);
        chk("wrap_down_d", 32'(d_w), 32'h999);
        chk("wrap_down_ovf", 32'(ov_w), 32'h1);
        chk("sat_down_d", 32'(d_s), 32'h000);
        chk("sat_down_ovf", 32'(ov_s), 32'h1);
        up = 1'b1;

        pulse_clr();
        run_ticks(25);
        pulse_lap();
        chk("lap_on_la", 32'(la_w), 32'h1);
        run_ticks(8);
        chk("lap_frozen_d", 32'(d_w), 32'h025);
        chk("lap_frozen_la", 32'(la_w), 32'h1);
        pulse_lap();
        chk("lap_off_d", 32'(d_w), 32'h033);
        chk("lap_off_la", 32'(la_w), 32'h0);

        pulse_clr();
        run_ticks(7);
        repeat (100) @(negedge clk);
        chk("paused_d", 32'(d_w), 32'h007);
        pulse_lap();
        chk("mid_lap_la", 32'(la_w), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_d", 32'(d_w), 32'h000);
        chk("async_rst_la", 32'(la_w), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            go  = ($urandom_range(0, 9) < 7);
            up  = ($urandom_range(0, 9) < 6);
            clr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 7) == 0) lap = ~lap;
            @(negedge clk);
        end
        go = 1'b0; clr = 1'b0; lap = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
